// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column-strobed row sampling, whole-keypad debounce,
// single-press event generation and a 32-bit hex entry shift register.
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  row,
   input  logic        clear,
   output logic [3:0]  col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic        multi_key,
   output logic [31:0] entry,
   output logic [3:0]  digit_count
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    row_s1_q, row_s2_q;
   logic [15:0]   snap_q, snap_d;
   logic [15:0]   prev_q, prev_d;
   logic [15:0]   stable_q, stable_d;
   logic [3:0]    match_q, match_d;
   logic          valid_q, valid_d;
   logic [3:0]    code_q, code_d;
   logic          held_q, held_d;
   logic          multi_q, multi_d;
   logic [31:0]   entry_q, entry_d;
   logic [3:0]    count_q, count_d;

   logic          scan_done;
   logic [4:0]    ones;
   logic [3:0]    key_idx;

   // Snapshot bit 4*c+r -> hex legend printed on the keypad.
   function automatic logic [3:0] key_of(input logic [3:0] idx);
      case (idx)
         4'd0:  key_of = 4'h1;
         4'd1:  key_of = 4'h4;
         4'd2:  key_of = 4'h7;
         4'd3:  key_of = 4'h0;
         4'd4:  key_of = 4'h2;
         4'd5:  key_of = 4'h5;
         4'd6:  key_of = 4'h8;
         4'd7:  key_of = 4'hF;
         4'd8:  key_of = 4'h3;
         4'd9:  key_of = 4'h6;
         4'd10: key_of = 4'h9;
         4'd11: key_of = 4'hE;
         4'd12: key_of = 4'hA;
         4'd13: key_of = 4'hB;
         4'd14: key_of = 4'hC;
         default: key_of = 4'hD;
      endcase
   endfunction

   always_comb begin
      dwell_d   = dwell_q;
      col_d     = col_q;
      snap_d    = snap_q;
      prev_d    = prev_q;
      stable_d  = stable_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      code_d    = code_q;
      entry_d   = entry_q;
      count_d   = count_q;
      scan_done = 1'b0;
      ones      = '0;
      key_idx   = '0;

      if (dwell_q == DW'(SCAN_DIV - 1)) begin
         dwell_d = '0;
         snap_d[{col_q, 2'b00} +: 4] = ~row_s2_q;
         col_d = col_q + 2'd1;
         scan_done = (col_q == 2'd3);
      end else begin
         dwell_d = dwell_q + DW'(1);
      end

      if (scan_done) begin
         if (snap_d != prev_q) begin
            prev_d  = snap_d;
            match_d = 4'd1;
         end else if (match_q != 4'(DEBOUNCE_SCANS)) begin
            match_d = match_q + 4'd1;
         end
         if (match_d == 4'(DEBOUNCE_SCANS)) begin
            stable_d = prev_d;
         end
      end

      for (int i = 0; i < 16; i++) begin
         ones = ones + 5'(stable_d[i]);
         if (stable_d[i]) key_idx = 4'(i);
      end
      held_d  = |stable_d;
      multi_d = (ones >= 5'd2);

      // Only an idle-to-single-key transition is a press; stable_d only moves on scan_done.
      if ((stable_q == 16'h0) && (ones == 5'd1)) begin
         valid_d = 1'b1;
         code_d  = key_of(key_idx);
         entry_d = {entry_q[27:0], code_d};
         count_d = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
      end

      if (clear) begin
         entry_d = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dwell_q  <= '0;
         col_q    <= '0;
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
         snap_q   <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         match_q  <= '0;
         valid_q  <= 1'b0;
         code_q   <= '0;
         held_q   <= 1'b0;
         multi_q  <= 1'b0;
         entry_q  <= '0;
         count_q  <= '0;
      end else begin
         dwell_q  <= dwell_d;
         col_q    <= col_d;
         row_s1_q <= row;
         row_s2_q <= row_s1_q;
         snap_q   <= snap_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         match_q  <= match_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         held_q   <= held_d;
         multi_q  <= multi_d;
         entry_q  <= entry_d;
         count_q  <= count_d;
      end
   end

   assign col         = ~(4'b0001 << col_q);
   assign key_valid   = valid_q;
   assign key_code    = code_q;
   assign key_held    = held_q;
   assign multi_key   = multi_q;
   assign entry       = entry_q;
   assign digit_count = count_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model driven by col, a per-scan
// reference model of debounce/event/entry rules, directed plus random presses.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  row;
   logic        clear;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic        multi_key;
   logic [31:0] entry;
   logic [3:0]  digit_count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] mask_cur = 16'h0;
   logic [15:0] km [4];

   logic [15:0] m_hist [$];
   logic [15:0] m_stable;
   logic [3:0]  m_code;
   logic [31:0] m_entry;
   logic [3:0]  m_count;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .reset(reset), .row(row), .clear(clear), .col(col),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
      .multi_key(multi_key), .entry(entry), .digit_count(digit_count)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its row to the driven-low column.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!col[c] && mask_cur[4*c + r]) row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] code_of(input int idx);
      logic [15:0] line;
      line = km[idx % 4];
      return line[(3 - idx / 4) * 4 +: 4];
   endfunction

   function automatic logic [15:0] key_mask(input logic [3:0] code);
      for (int i = 0; i < 16; i++)
         if (code_of(i) == code) return 16'(1) << i;
      return 16'h0;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_stable = '0;
      m_code   = '0;
      m_entry  = '0;
      m_count  = '0;
   endtask

   task automatic check_reset_state();
      check("rst_col", 32'(col), 32'hE);
      check("rst_valid", 32'(key_valid), 0);
      check("rst_code", 32'(key_code), 0);
      check("rst_held", 32'(key_held), 0);
      check("rst_multi", 32'(multi_key), 0);
      check("rst_entry", entry, 0);
      check("rst_count", 32'(digit_count), 0);
   endtask

   // One full scan with the keypad held at mask; clr_cycle (1..16) pulses clear before that edge.
   task automatic run_scan(input logic [15:0] mask, input int clr_cycle);
      int          pulses;
      logic        eq, ev;
      logic [15:0] new_st;
      logic [3:0]  exp_col;
      mask_cur = mask;
      pulses = 0;
      for (int j = 1; j <= 16; j++) begin
         if (clr_cycle == j) clear = 1'b1;
         @(posedge clk);
         #1;
         clear = 1'b0;
         if (key_valid) pulses++;
         exp_col = ~(4'b0001 << ((j / 4) % 4));
         check("col", 32'(col), 32'(exp_col));
      end

      m_hist.push_back(mask);
      if (m_hist.size() > DS) void'(m_hist.pop_front());
      new_st = m_stable;
      if (m_hist.size() == DS) begin
         eq = 1'b1;
         foreach (m_hist[k]) if (m_hist[k] != mask) eq = 1'b0;
         if (eq) new_st = mask;
      end
      ev = (m_stable == 16'h0) && ($countones(new_st) == 1);
      if (clr_cycle != 0 && clr_cycle < 16) begin
         m_entry = '0;
         m_count = '0;
      end
      if (ev) begin
         for (int i = 0; i < 16; i++) if (new_st[i]) m_code = code_of(i);
         m_entry = {m_entry[27:0], m_code};
         m_count = (m_count == 4'd8) ? 4'd8 : m_count + 4'd1;
      end
      if (clr_cycle == 16) begin
         m_entry = '0;
         m_count = '0;
      end
      m_stable = new_st;

      check("pulses", 32'(pulses), 32'(ev));
      check("valid_end", 32'(key_valid), 32'(ev));
      check("code", 32'(key_code), 32'(m_code));
      check("held", 32'(key_held), 32'(m_stable != 0));
      check("multi", 32'(multi_key), 32'($countones(m_stable) >= 2));
      check("entry", entry, m_entry);
      check("count", 32'(digit_count), 32'(m_count));
      $display("[TB] scan mask=%h clr=%0d valid=%0d code=%h entry=%h count=%0d",
               mask, clr_cycle, key_valid, key_code, entry, digit_count);
   endtask

   task automatic press_key(input logic [3:0] code);
      run_scan(key_mask(code), 0);
      run_scan(key_mask(code), 0);
      run_scan(16'h0, 0);
      run_scan(16'h0, 0);
   endtask

   initial begin
      km[0] = 16'h123A;
      km[1] = 16'h456B;
      km[2] = 16'h789C;
      km[3] = 16'h0FED;
      reset = 1'b1;
      clear = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      @(negedge clk);
      reset = 1'b0;

      // Idle keypad.
      repeat (3) run_scan(16'h0, 0);

      // Held "5": one event, no auto-repeat, then a second press.
      repeat (12) run_scan(key_mask(4'h5), 0);
      press_key(4'h5);
      run_scan(16'h0, 16);

      // Digit sequence and entry saturation.
      press_key(4'h1);
      press_key(4'h2);
      press_key(4'hA);
      press_key(4'hD);
      check("entry_12AD", entry, 32'h0000_12AD);
      for (int d = 3; d <= 10; d++) press_key(4'(d));
      check("entry_full", entry, 32'h3456_789A);
      check("count_sat", 32'(digit_count), 8);

      // Bouncing "7", then steady.
      for (int b = 0; b < 6; b++) run_scan((b % 2 == 0) ? key_mask(4'h7) : 16'h0, 0);
      repeat (2) run_scan(key_mask(4'h7), 0);
      repeat (2) run_scan(16'h0, 0);

      // "3" then "B" added and removed.
      repeat (2) run_scan(key_mask(4'h3), 0);
      repeat (3) run_scan(key_mask(4'h3) | key_mask(4'hB), 0);
      check("multi_3B", 32'(multi_key), 1);
      repeat (2) run_scan(key_mask(4'h3), 0);
      repeat (2) run_scan(16'h0, 0);
      press_key(4'h6);

      // Clear coincident with the "E" event.
      run_scan(key_mask(4'hE), 0);
      run_scan(key_mask(4'hE), 16);
      check("clr_valid", 32'(key_valid), 1);
      check("clr_code", 32'(key_code), 32'hE);
      check("clr_entry", entry, 0);
      run_scan(16'h0, 0);
      run_scan(16'h0, 0);

      // Reset mid-scan with "9" held.
      mask_cur = key_mask(4'h9);
      run_scan(key_mask(4'h9), 0);
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_state();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (2) run_scan(key_mask(4'h9), 0);
      check("rst_reaccept", 32'(key_code), 32'h9);
      repeat (2) run_scan(16'h0, 0);

      // Random press patterns held for random scan counts.
      for (int seg = 0; seg < 60; seg++) begin
         int          kind, n, clr;
         logic [15:0] m;
         kind = int'($urandom_range(0, 3));
         n    = int'($urandom_range(1, 4));
         clr  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : 0;
         m    = 16'h0;
         if (kind != 0) m = 16'(1) << $urandom_range(0, 15);
         if (kind == 3) m = m | (16'(1) << $urandom_range(0, 15));
         for (int s = 0; s < n; s++) run_scan(m, (s == n - 1) ? clr : 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 hex keypad (Pmod KYPD layout) by driving one column low at a time and sampling the active-low row inputs. It debounces the whole 16-key state and emits one event per clean single-key press. Entered hex digits are shifted into a 32-bit entry register. It is the input-side counterpart of the board's multiplexed seven-segment output path: the scanner produces operator data, and the display path consumes it.

## Interface
- SCAN_DIV, 50000: clk cycles each column stays driven (0.5 ms at 100 MHz); legal range ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required before the key state is accepted; legal range 1..15.

- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- row  in  4  keypad rows, active-low (pulled up off-chip), asynchronous to clk
- clear  in  1  synchronous clear of entry/digit_count
- col  out  4  keypad column drive, active-low, exactly one bit low at all times
- key_valid  out  1  one-cycle pulse: new debounced single-key press
- key_code  out  4  hex value of last accepted key; holds between events
- key_held  out  1  debounced state has ≥1 key down
- multi_key  out  1  debounced state has ≥2 keys down
- entry  out  32  shift register of entered digits, newest in [3:0]
- digit_count  out  4  digits entered since reset/clear, saturates at 8

## Operation
- Key map (row r, column c → code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- row passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Dwell counter runs 0..SCAN_DIV-1. At terminal count, the scanner:
  - samples synchronized row into the 4 snapshot bits of the current column (bit index = 4·c + r, 1 = pressed);
  - advances the column 0→1→2→3→0;
  - drives col = ~(1<<c).
- The terminal count of column 3 completes a scan and produces a 16-bit snapshot.
- Debounce, evaluated once per completed scan:
  - snapshot ≠ prev: prev ← snapshot, match_cnt ← 1.
  - snapshot = prev: match_cnt increments, saturating at DEBOUNCE_SCANS.
  - When match_cnt reaches DEBOUNCE_SCANS (including DEBOUNCE_SCANS=1 on first scan), stable ← prev.
- Outputs from stable:
  - key_held = |stable.
  - multi_key = popcount(stable) ≥ 2.
- Event rule: key_valid pulses only when stable changes from all-zero to exactly one bit set.
  - key_code ← code of that bit.
  - Transitions from a nonzero state (second key added, partial release) never generate an event.
  - Stable must return to zero before another event is possible (no auto-repeat).
- Entry update on key_valid: entry ← {entry[27:0], key_code}, digit_count ← min(digit_count+1, 8). Older digits fall off [31:28].
- clear:
  - Sets entry ← 0 and digit_count ← 0.
  - If clear coincides with key_valid, clear wins: the entry stays 0, but key_valid and key_code still update.
  - clear does not affect scanning or debounce.

## Timing
- Reset values:
  - col = 4'b1110
  - key_valid = 0, key_code = 0, key_held = 0, multi_key = 0
  - entry = 0, digit_count = 0
  - Internal state: dwell counter 0, column 0, snapshot 0, prev 0, stable 0, match_cnt 0.
- Reset mid-scan or mid-debounce discards all partial state, and scanning restarts at column 0.
- One full scan = 4·SCAN_DIV cycles. Row is sampled at the end of the dwell, giving SCAN_DIV-1 cycles of settle after col changes.
- A press present at scan start is accepted at the end of scan DEBOUNCE_SCANS. A press arriving mid-scan may be missed in that scan, so it is accepted at the end of scan DEBOUNCE_SCANS+1 at most.
- stable, key_held, multi_key, key_valid, key_code, entry and digit_count all update on the same clock edge as the column-3 terminal count. key_valid is high for exactly that one following cycle.
- Bounce shorter than one scan that ends before the sample point is invisible. Any differing scan restarts the count.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2; scan = 16 cycles.
- Reset then idle, rows 4'hF: col cycles 1110→1101→1011→0111 every 4 cycles; key_valid never asserts; entry = 0.
- Hold key "5" (row1 low while col1 low) from scan start: one key_valid at end of the 2nd scan, key_code=5, entry=0x00000005, digit_count=1. Holding 10 more scans produces no further pulse. Release, then press again: a second pulse.
- Press "1","2","A","D", releasing between each: entry=0x000012AD, digit_count=4. Then enter 8 more digits 3..A: entry=0x3456789A, digit_count=8.
- Bounce: toggle the "7" row every scan for 5 scans, then hold steady: no event during toggling; exactly one event with key_code=7 after 2 steady scans.
- Hold "3", then add "B": one event, code 3 only; multi_key=1 after debounce; no event when "B" is released. A new event occurs only after all keys are released.
- clear asserted in the same cycle as the key_valid for "E": key_valid=1, key_code=E, entry=0, digit_count=0. Assert reset mid-scan with a key held: outputs return to reset values, and the press is re-accepted after 2 full scans.
